// File: rtl/icache_tag_lookup_if.sv
// icache_tag_lookup_if: lookup/fill bus between the cache datapath and the tag-lookup unit
interface icache_tag_lookup_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     access;
    logic                     fill;
    logic                     hit;
    logic [3:0]               hit_vector;
    logic [1:0]               hit_line;
    logic [1:0]               victim_line;
    logic [3:0]               valid_lines;

    modport master (
        output address, access, fill,
        input  hit, hit_vector, hit_line, victim_line, valid_lines
    );

    modport slave (
        input  address, access, fill,
        output hit, hit_vector, hit_line, victim_line, valid_lines
    );
endinterface

// File: rtl/icache_tag_lookup.sv
// icache_tag_lookup: tags, valid bits and LRU state of a 4-line fully associative icache
module icache_tag_lookup #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int TAG_WIDTH       = 28,
    parameter int CACHE_NUM_LINES = 4
) (
    input logic                clk,
    input logic                reset,
    icache_tag_lookup_if.slave bus
);
    logic [TAG_WIDTH-1:0]       r_tag [CACHE_NUM_LINES];
    logic [1:0]                 r_lru [CACHE_NUM_LINES];
    logic [CACHE_NUM_LINES-1:0] r_valid;
    logic [TAG_WIDTH-1:0]       w_tag;
    logic [CACHE_NUM_LINES-1:0] w_hit_vector;
    logic                       w_hit;
    logic [1:0]                 w_hit_line;
    logic [1:0]                 w_victim;
    logic                       w_install;
    logic                       w_touch;
    logic [1:0]                 w_touch_line;

    assign w_tag = bus.address[ADDRESS_WIDTH-1 -: TAG_WIDTH];

    // One comparator per line; an invalid line never hits
    always_comb begin
        w_hit_vector = '0;
        for (int i = 0; i < CACHE_NUM_LINES; i++)
            w_hit_vector[i] = r_valid[i] && (r_tag[i] == w_tag);
    end

    assign w_hit = |w_hit_vector;

    // Priority encoder (line 0 wins) and search for the line whose LRU counter is 0
    always_comb begin
        w_hit_line = '0;
        w_victim   = '0;
        for (int i = CACHE_NUM_LINES - 1; i >= 0; i--) begin
            if (w_hit_vector[i])
                w_hit_line = 2'(i);
            if (r_lru[i] == 2'd0)
                w_victim = 2'(i);
        end
    end

    // A miss fill installs into the victim; a hitting fill or access only refreshes recency
    assign w_install    = bus.fill && !w_hit;
    assign w_touch      = bus.fill || (bus.access && w_hit);
    assign w_touch_line = w_install ? w_victim : w_hit_line;

    // Valid bits and LRU permutation; reset restores counter[i] = i
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < CACHE_NUM_LINES; i++)
                r_lru[i] <= 2'(i);
        end else if (w_touch) begin
            if (w_install)
                r_valid[w_touch_line] <= 1'b1;
            for (int i = 0; i < CACHE_NUM_LINES; i++)
                r_lru[i] <= (2'(i) == w_touch_line) ? 2'd3 :
                            (r_lru[i] > r_lru[w_touch_line]) ? r_lru[i] - 2'd1 : r_lru[i];
        end
    end

    // Tag storage needs no reset since an invalid line never compares
    always_ff @(posedge clk) begin
        if (!reset && w_install)
            r_tag[w_touch_line] <= w_tag;
    end

    assign bus.hit         = w_hit;
    assign bus.hit_vector  = w_hit_vector;
    assign bus.hit_line    = w_hit_line;
    assign bus.victim_line = w_victim;
    assign bus.valid_lines = r_valid;
endmodule

// File: tb/tb_icache_tag_lookup.sv
// tb_icache_tag_lookup: directed and random checks against a recency-queue cache model
module tb_icache_tag_lookup;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    icache_tag_lookup_if #(.ADDRESS_WIDTH(32)) bus ();

    icache_tag_lookup dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [27:0] m_tag [4];
    bit          m_valid [4];
    int          m_order [$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_order = {0, 1, 2, 3};
        foreach (m_valid[i]) m_valid[i] = 0;
    endfunction

    function automatic void m_touch(int k);
        foreach (m_order[i])
            if (m_order[i] == k) begin
                m_order.delete(i);
                break;
            end
        m_order.push_back(k);
    endfunction

    function automatic int m_lookup(logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_tag[i] == a[31:4]) return i;
        return -1;
    endfunction

    task automatic check_all(string name);
        logic [3:0] vec, vl;
        int hl;
        hl = m_lookup(bus.address);
        for (int i = 0; i < 4; i++) begin
            vec[i] = m_valid[i] && m_tag[i] == bus.address[31:4];
            vl[i]  = m_valid[i];
        end
        chk({name, ".hit"}, 32'(bus.hit), 32'(hl >= 0));
        chk({name, ".vec"}, 32'(bus.hit_vector), 32'(vec));
        chk({name, ".line"}, 32'(bus.hit_line), (hl >= 0) ? 32'(hl) : 32'd0);
        chk({name, ".victim"}, 32'(bus.victim_line), 32'(m_order[0]));
        chk({name, ".valid"}, 32'(bus.valid_lines), 32'(vl));
    endtask

    task automatic cycle(bit f, bit a, logic [31:0] addr, string name);
        int hl;
        @(negedge clk);
        bus.fill = f;
        bus.access = a;
        bus.address = addr;
        #1 check_all(name);
        @(posedge clk);
        if (!reset) begin
            hl = m_lookup(addr);
            if (f && hl < 0) begin
                m_tag[m_order[0]]   = addr[31:4];
                m_valid[m_order[0]] = 1;
                m_touch(m_order[0]);
            end else if ((f || a) && hl >= 0) begin
                m_touch(hl);
            end
        end
    endtask

    task automatic look(logic [31:0] addr, string name);
        @(negedge clk);
        bus.fill = 0;
        bus.access = 0;
        bus.address = addr;
        #1 check_all(name);
    endtask

    task automatic sync_reset();
        @(negedge clk);
        reset = 1;
        m_reset();
        @(negedge clk);
        reset = 0;
    endtask

    logic [31:0] pool [6] = '{32'h0000_1230, 32'h8000_1230, 32'h0000_1000,
                              32'h0000_2000, 32'h0000_3000, 32'h0000_5000};

    initial begin
        bus.fill = 0;
        bus.access = 0;
        bus.address = 32'h0000_1230;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;

        look(32'h0000_1230, "rst_look");
        chk("rst_hit", 32'(bus.hit), 0);
        chk("rst_valid", 32'(bus.valid_lines), 0);
        chk("rst_victim", 32'(bus.victim_line), 0);

        cycle(1, 0, 32'h0000_1230, "fill1");
        look(32'h0000_123C, "look1");
        chk("l1_hit", 32'(bus.hit), 1);
        chk("l1_line", 32'(bus.hit_line), 0);
        chk("l1_vec", 32'(bus.hit_vector), 1);
        chk("l1_victim", 32'(bus.victim_line), 1);

        sync_reset();
        cycle(1, 0, 32'h0000_1000, "f1000");
        cycle(1, 0, 32'h0000_2000, "f2000");
        cycle(1, 0, 32'h0000_3000, "f3000");
        cycle(1, 0, 32'h0000_4000, "f4000");
        look(32'h0000_4000, "l4000");
        chk("full_victim", 32'(bus.victim_line), 0);
        chk("full_valid", 32'(bus.valid_lines), 32'hF);
        chk("l4000_line", 32'(bus.hit_line), 3);
        cycle(0, 1, 32'h0000_1000, "a1000");
        look(32'h0000_1000, "post_a");
        chk("acc_victim", 32'(bus.victim_line), 1);

        cycle(1, 0, 32'h0000_5000, "f5000");
        look(32'h0000_2000, "l2000");
        chk("evict_miss", 32'(bus.hit), 0);
        look(32'h0000_5000, "l5000");
        chk("repl_hit", 32'(bus.hit), 1);
        chk("repl_line", 32'(bus.hit_line), 1);

        cycle(1, 1, 32'h0000_1000, "dupfill");
        look(32'h0000_1000, "post_dup");
        chk("dup_valid", 32'(bus.valid_lines), 32'hF);
        chk("dup_victim", 32'(bus.victim_line), 2);

        cycle(1, 0, 32'h0000_1230, "f1230");
        look(32'h8000_1230, "bit31");
        chk("bit31_miss", 32'(bus.hit), 0);
        look(32'h0000_1230, "l1230");
        chk("pre_rst_hit", 32'(bus.hit), 1);

        #2 reset = 1;
        m_reset();
        #1 check_all("async_rst");
        chk("async_hit", 32'(bus.hit), 0);
        chk("async_victim", 32'(bus.victim_line), 0);
        bus.fill = 1;
        bus.address = 32'h0000_9990;
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        bus.fill = 0;
        #1 check_all("rst_fill_drop");
        chk("drop_valid", 32'(bus.valid_lines), 0);

        cycle(1, 0, 32'h0000_A000, "r0");
        cycle(1, 0, 32'h0000_B000, "r1");
        cycle(1, 0, 32'h0000_C000, "r2");
        cycle(1, 0, 32'h0000_D000, "r3");
        look(32'h0000_D000, "rfill_done");

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 15));
            cycle(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, "rand");
        end
        look(32'h0000_1000, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_tag_lookup.md
# icache_tag_lookup

Tag-lookup and replacement unit for the 4-line, fully associative instruction cache. It holds the per-line tags, valid bits and LRU state. Each line has a tag comparator; a priority encoder turns the comparator outputs into a hit flag and a line index. The unit also names the LRU victim line for refills. The cache datapath uses its outputs to select data-array words and to decide when to request a line from memory.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 32: CPU address width.
- `TAG_WIDTH`, default 28: tag width, taken from `address[31:4]`.
- `CACHE_NUM_LINES`, default 4: number of lines. This is fixed at 4 and is not scalable.

Ports:
- `clk` in, 1 bit: the single clock. All state changes on the rising edge.
- `reset` in, 1 bit: asynchronous, active-high.
- `address` in, `ADDRESS_WIDTH` bits: lookup address. Bits [31:4] are the tag, [3:2] the word offset, [1:0] the byte offset. The offsets are ignored here.
- `access` in, 1 bit: when high at a rising edge with `hit`=1, marks `hit_line` as most recently used.
- `fill` in, 1 bit: when high at a rising edge, installs the tag of `address` into a line.
- `hit` out, 1 bit: combinational. High when any valid line's tag equals `address[31:4]`.
- `hit_vector` out, 4 bits: combinational. Bit i = `valid[i] && tag[i] == address[31:4]`.
- `hit_line` out, 2 bits: combinational. Lowest-indexed set bit of `hit_vector`; 0 when there is no hit.
- `victim_line` out, 2 bits: combinational. The line whose LRU counter is 0.
- `valid_lines` out, 4 bits: registered valid bits.

## Operation
- Each line stores a 28-bit tag, a valid bit and a 2-bit LRU counter.
- At all times the LRU counters form a permutation of {0,1,2,3}. Value 3 means most recently used; value 0 means least recently used.
- Tag comparator, one per line: `hit_i = valid_i & (stored_tag_i == address[31:4])`. An invalid line never hits, even if its tag matches.
- Priority encoder: line 0 has the highest priority. Duplicate tags cannot arise, but the encoder must still be deterministic if they do.
- LRU touch of line k:
  - every line whose counter is greater than counter[k] decrements by 1;
  - counter[k] becomes 3;
  - the permutation property is preserved.
- Rising edge, no reset, actions in priority order:
  1. `fill`=1 and `hit`=0: write the tag to `victim_line`, set its valid bit, and LRU-touch that line.
  2. `fill`=1 and `hit`=1: do not install a duplicate; LRU-touch `hit_line`.
  3. `access`=1 and `hit`=1: LRU-touch `hit_line`.
  4. `access`=1 and `hit`=0: no state change.
  5. Neither input high: no state change.
- `fill` and `access` high together is handled as `fill` alone.

## Timing
- `reset` high, applied immediately and without waiting for `clk`:
  - all valid bits clear;
  - counter[i] = i;
  - tags are don't-care.
- Outputs while in reset: `hit`=0, `hit_vector`=0, `hit_line`=0, `victim_line`=0, `valid_lines`=0.
- Reset asserted in the middle of any sequence aborts it. A fill or access sampled at the same edge as reset is discarded.
- Lookup latency is zero cycles: `hit`, `hit_vector` and `hit_line` follow `address` combinationally from the current state.
- A fill or access takes effect at the rising edge. The new state becomes visible on the outputs immediately after that edge, so a lookup of the filled tag hits in the next cycle.
- There is no handshake. `access` and `fill` are level-sampled once per edge; holding `fill` high for N edges performs N fills.

## Test plan
- Reset, then drive address 0x0000_1230: `hit`=0, `valid_lines`=0000, `victim_line`=0.
- Fill 0x0000_1230 for one edge, then look up 0x0000_123C: `hit`=1, `hit_line`=0, `hit_vector`=0001, `victim_line`=1.
- Fill tags 0x1000, 0x2000, 0x3000 and 0x4000 on consecutive edges: the lines fill in order 0–3 and `victim_line` returns to 0. Then access 0x1000: `victim_line` becomes 1.
- Fill 0x5000 after the previous scenario: it replaces line 1. Lookup of 0x2000 misses; 0x5000 hits with `hit_line`=1.
- Fill 0x1000 again while it is already resident: no second line is used, `valid_lines` is unchanged and 0x1000 becomes MRU. Separately, address 0x8000_1230 misses against 0x0000_1230, since only bit 31 differs.
- Assert `reset` asynchronously between edges while `hit`=1: `hit` falls to 0 at once and the counters return to 0,1,2,3.
